// File: rtl/cache_refill_writer_if.sv
// Bundles the refill-request, bus-beat, BRAM port-A and status signals of
// the cache refill writer. The engine uses the slave view; the requester,
// bus and BRAM side together form the master view.
interface cache_refill_writer_if #(
    parameter int LEN_DATA   = 32,
    parameter int LEN_ADDR   = 10,
    parameter int LINE_WORDS = 8
);
    localparam int OFS_W = $clog2(LINE_WORDS);
    localparam int IDX_W = LEN_ADDR - OFS_W;
    localparam int NB    = LEN_DATA / 8;

    // refill request
    logic                req_valid;
    logic                req_ready;
    logic [IDX_W-1:0]    req_index;
    logic [OFS_W-1:0]    req_offset;
    logic [NB-1:0]       req_wstrb;
    logic [LEN_DATA-1:0] req_wdata;

    // bus data beats
    logic                beat_valid;
    logic                beat_ready;
    logic [LEN_DATA-1:0] beat_data;
    logic                beat_last;

    // BRAM port A
    logic                bram_en;
    logic [NB-1:0]       bram_we;
    logic [LEN_ADDR-1:0] bram_addr;
    logic [LEN_DATA-1:0] bram_din;

    // pipeline forwarding and status
    logic                crit_valid;
    logic [LEN_DATA-1:0] crit_data;
    logic                done;
    logic                err;

    modport master (
        output req_valid, req_index, req_offset, req_wstrb, req_wdata,
        output beat_valid, beat_data, beat_last,
        input  req_ready, beat_ready,
        input  bram_en, bram_we, bram_addr, bram_din,
        input  crit_valid, crit_data, done, err
    );

    modport slave (
        input  req_valid, req_index, req_offset, req_wstrb, req_wdata,
        input  beat_valid, beat_data, beat_last,
        output req_ready, beat_ready,
        output bram_en, bram_we, bram_addr, bram_din,
        output crit_valid, crit_data, done, err
    );
endinterface

// File: rtl/cache_refill_writer.sv
// Cache line refill engine. Takes one refill request per miss, writes a
// wrapping burst of bus beats into the data bank BRAM starting at the
// critical word, merges a pending store into that word and forwards it to
// the pipeline the cycle it is written.
module cache_refill_writer #(
    parameter int LEN_DATA   = 32,
    parameter int LEN_ADDR   = 10,
    parameter int LINE_WORDS = 8
) (
    input logic                   clk,
    input logic                   rst,
    cache_refill_writer_if.slave  bus
);
    localparam int OFS_W = $clog2(LINE_WORDS);
    localparam int IDX_W = LEN_ADDR - OFS_W;
    localparam int NB    = LEN_DATA / 8;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_FILL = 1'b1;

    localparam logic [OFS_W:0] CNT_LAST = (OFS_W+1)'(LINE_WORDS - 1);
    localparam logic [OFS_W:0] CNT_ONE  = (OFS_W+1)'(1);

    logic [0:0]          state;
    logic [OFS_W:0]      cnt;
    logic [IDX_W-1:0]    idx_q;
    logic [OFS_W-1:0]    ofs_q;
    logic [NB-1:0]       wstrb_q;
    logic [LEN_DATA-1:0] wdata_q;

    logic [OFS_W-1:0]    word_ofs;
    logic [LEN_DATA-1:0] merged;
    logic                crit_beat;
    logic                last_slot;
    logic                term;

    // Handshake readiness depends on state only, never on the other side's valid.
    assign bus.req_ready  = (state == S_IDLE);
    assign bus.beat_ready = (state == S_FILL);

    // Wrapped word offset, store merge and burst-termination decode for the current beat.
    always_comb begin
        // NOTE: every output of this block gets a value before any condition, so no latch is inferred.
        word_ofs  = ofs_q + cnt[OFS_W-1:0];
        crit_beat = (cnt == '0);
        last_slot = (cnt == CNT_LAST);
        term      = bus.beat_last || last_slot;
        merged    = bus.beat_data;
        for (int b = 0; b < NB; b++) begin
            if (wstrb_q[b]) begin
                merged[8*b +: 8] = wdata_q[8*b +: 8];
            end
        end
    end

    // Request latch, beat counting and registered BRAM write / status outputs.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state          <= S_IDLE;
            cnt            <= '0;
            idx_q          <= '0;
            ofs_q          <= '0;
            wstrb_q        <= '0;
            wdata_q        <= '0;
            bus.bram_en    <= 1'b0;
            bus.bram_we    <= '0;
            bus.bram_addr  <= '0;
            bus.bram_din   <= '0;
            bus.crit_valid <= 1'b0;
            bus.crit_data  <= '0;
            bus.done       <= 1'b0;
            bus.err        <= 1'b0;
        end else begin
            // Strobes default low; address, data and critical word hold.
            bus.bram_en    <= 1'b0;
            bus.bram_we    <= '0;
            bus.crit_valid <= 1'b0;
            bus.done       <= 1'b0;
            bus.err        <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        idx_q   <= bus.req_index;
                        ofs_q   <= bus.req_offset;
                        wstrb_q <= bus.req_wstrb;
                        wdata_q <= bus.req_wdata;
                        cnt     <= '0;
                        state   <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (bus.beat_valid) begin
                        bus.bram_en   <= 1'b1;
                        bus.bram_we   <= '1;
                        bus.bram_addr <= {idx_q, word_ofs};
                        bus.bram_din  <= crit_beat ? merged : bus.beat_data;
                        cnt           <= cnt + CNT_ONE;
                        if (crit_beat) begin
                            bus.crit_valid <= 1'b1;
                            bus.crit_data  <= merged;
                        end
                        if (term) begin
                            bus.done <= 1'b1;
                            bus.err  <= !(bus.beat_last && last_slot);
                            state    <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_refill_writer.sv
// Directed bench for cache_refill_writer: aligned and wrapped fills, store
// merge, burst length errors, mid-burst reset and back-to-back requests.
module tb_cache_refill_writer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    cache_refill_writer_if bus ();

    cache_refill_writer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        en;
        logic [3:0]  we;
        logic [9:0]  addr;
        logic [31:0] din;
        logic        crit;
        logic [31:0] cdata;
        logic        done;
        logic        err;
        int          cyc;
    } rec_t;

    rec_t log_q[$];

    // Record every cycle in which the engine writes or raises a status pulse.
    always @(negedge clk) begin
        if (bus.bram_en || bus.crit_valid || bus.done) begin
            log_q.push_back('{bus.bram_en, bus.bram_we, bus.bram_addr, bus.bram_din,
                              bus.crit_valid, bus.crit_data, bus.done, bus.err, cyc});
        end
    end

    function automatic logic [49:0] exp_wr(input int addr, input logic [31:0] din,
                                           input bit crit, input bit dn, input bit er);
        return {1'b1, 4'hF, 10'(addr), din, crit, dn, er};
    endfunction

    function automatic logic [49:0] got_wr(input rec_t r);
        return {r.en, r.we, r.addr, r.din, r.crit, r.done, r.err};
    endfunction

    task automatic send_req(input int idx, input int ofs, input logic [3:0] ws, input logic [31:0] wd);
        int n = 0;
        bus.req_valid  = 1'b1;
        bus.req_index  = 7'(idx);
        bus.req_offset = 3'(ofs);
        bus.req_wstrb  = ws;
        bus.req_wdata  = wd;
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            n_cmp++; n_bad++;
            $display("FAIL req_timeout: req_ready=%0b, required 1 within 50 cycles", bus.req_ready);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    // Beat i carries base+i; beat last_at (if in range) has beat_last set.
    task automatic send_burst(input logic [31:0] base, input int n, input int last_at,
                              input int gap, output int c0);
        c0 = cyc;
        for (int i = 0; i < n; i++) begin
            int w = 0;
            bus.beat_valid = 1'b1;
            bus.beat_data  = base + 32'(i);
            bus.beat_last  = (i == last_at);
            while (!bus.beat_ready && w < 50) begin
                @(negedge clk);
                w++;
            end
            if (w >= 50) begin
                n_cmp++; n_bad++;
                $display("FAIL beat_timeout: beat %0d beat_ready=%0b, required 1", i, bus.beat_ready);
            end
            @(negedge clk);
            bus.beat_valid = 1'b0;
            bus.beat_last  = 1'b0;
            if (i != n - 1) repeat (gap) @(negedge clk);
        end
    endtask

    task automatic settle;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset;
        logic [115:0] got;
        got = {bus.bram_en, bus.bram_we, bus.bram_addr, bus.bram_din, bus.crit_valid,
               bus.crit_data, bus.done, bus.err, bus.req_ready, bus.beat_ready};
        n_cmp++;
        if (got !== {1'b0, 4'h0, 10'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h required all zero with req_ready=1 beat_ready=0", got);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_aligned;
        int c0;
        log_q.delete();
        send_req(5, 0, 4'h0, 32'h0);
        send_burst(32'h100, 8, 7, 0, c0);
        settle();
        n_cmp++;
        if (log_q.size() !== 8) begin
            n_bad++;
            $display("FAIL aligned_count: got %0d writes, required 8", log_q.size());
        end
        for (int i = 0; i < 8 && i < log_q.size(); i++) begin
            n_cmp++;
            if (got_wr(log_q[i]) !== exp_wr(8'h28 + i, 32'h100 + i, i == 0, i == 7, 1'b0)) begin
                n_bad++;
                $display("FAIL aligned_write%0d: got %h required %h", i, got_wr(log_q[i]),
                         exp_wr(8'h28 + i, 32'h100 + i, i == 0, i == 7, 1'b0));
            end
        end
        if (log_q.size() == 8) begin
            n_cmp++;
            if (log_q[0].cdata !== 32'h100) begin
                n_bad++;
                $display("FAIL aligned_crit_data: got %h required 00000100", log_q[0].cdata);
            end
            // Presentation cycle plus eight write cycles: done seen LINE_WORDS cycles after presentation.
            n_cmp++;
            if (log_q[7].cyc - c0 !== 8) begin
                n_bad++;
                $display("FAIL aligned_latency: got %0d cycles, required 8", log_q[7].cyc - c0);
            end
        end
    endtask

    task automatic test_wrapped;
        int c0;
        int exp_ofs[8] = '{6, 7, 0, 1, 2, 3, 4, 5};
        log_q.delete();
        send_req(3, 6, 4'h0, 32'h0);
        send_burst(32'hA0, 8, 7, 1, c0);
        settle();
        n_cmp++;
        if (log_q.size() !== 8) begin
            n_bad++;
            $display("FAIL wrapped_count: got %0d writes, required 8", log_q.size());
        end
        for (int i = 0; i < 8 && i < log_q.size(); i++) begin
            n_cmp++;
            if (got_wr(log_q[i]) !== exp_wr(24 + exp_ofs[i], 32'hA0 + i, i == 0, i == 7, 1'b0)) begin
                n_bad++;
                $display("FAIL wrapped_write%0d: got %h required %h", i, got_wr(log_q[i]),
                         exp_wr(24 + exp_ofs[i], 32'hA0 + i, i == 0, i == 7, 1'b0));
            end
            if (i > 0) begin
                n_cmp++;
                if (log_q[i].cyc - log_q[i-1].cyc !== 2) begin
                    n_bad++;
                    $display("FAIL wrapped_spacing%0d: got %0d cycles, required 2", i,
                             log_q[i].cyc - log_q[i-1].cyc);
                end
            end
        end
    endtask

    task automatic test_merge;
        int c0;
        log_q.delete();
        send_req(1, 2, 4'b0101, 32'hAABBCCDD);
        send_burst(32'h11223344, 8, 7, 0, c0);
        settle();
        n_cmp++;
        if (log_q.size() !== 8) begin
            n_bad++;
            $display("FAIL merge_count: got %0d writes, required 8", log_q.size());
        end
        if (log_q.size() == 8) begin
            n_cmp++;
            if (got_wr(log_q[0]) !== exp_wr(8'h0A, 32'h11BB33DD, 1, 0, 0)) begin
                n_bad++;
                $display("FAIL merge_crit_write: got %h required %h", got_wr(log_q[0]),
                         exp_wr(8'h0A, 32'h11BB33DD, 1, 0, 0));
            end
            n_cmp++;
            if (log_q[0].cdata !== 32'h11BB33DD) begin
                n_bad++;
                $display("FAIL merge_crit_data: got %h required 11bb33dd", log_q[0].cdata);
            end
            n_cmp++;
            if (got_wr(log_q[1]) !== exp_wr(8'h0B, 32'h11223345, 0, 0, 0)) begin
                n_bad++;
                $display("FAIL merge_next_word: got %h required %h", got_wr(log_q[1]),
                         exp_wr(8'h0B, 32'h11223345, 0, 0, 0));
            end
            n_cmp++;
            if (got_wr(log_q[7]) !== exp_wr(8'h09, 32'h1122334B, 0, 1, 0)) begin
                n_bad++;
                $display("FAIL merge_last_word: got %h required %h", got_wr(log_q[7]),
                         exp_wr(8'h09, 32'h1122334B, 0, 1, 0));
            end
        end
    endtask

    task automatic test_length_errors;
        int c0;
        // Early beat_last on the fifth beat.
        log_q.delete();
        send_req(2, 0, 4'h0, 32'h0);
        send_burst(32'h300, 5, 4, 0, c0);
        n_cmp++;
        if ({bus.req_ready, bus.beat_ready} !== 2'b10) begin
            n_bad++;
            $display("FAIL early_ready: got req/beat ready %b, required 10", {bus.req_ready, bus.beat_ready});
        end
        settle();
        n_cmp++;
        if (log_q.size() !== 5) begin
            n_bad++;
            $display("FAIL early_count: got %0d writes, required 5", log_q.size());
        end
        if (log_q.size() == 5) begin
            n_cmp++;
            if (got_wr(log_q[4]) !== exp_wr(8'h14, 32'h304, 0, 1, 1)) begin
                n_bad++;
                $display("FAIL early_final: got %h required %h", got_wr(log_q[4]),
                         exp_wr(8'h14, 32'h304, 0, 1, 1));
            end
            n_cmp++;
            if (log_q[3].done !== 1'b0) begin
                n_bad++;
                $display("FAIL early_premature_done: got %b required 0", log_q[3].done);
            end
        end
        // Eight beats without beat_last.
        log_q.delete();
        send_req(4, 3, 4'h0, 32'h0);
        send_burst(32'h400, 8, -1, 0, c0);
        settle();
        n_cmp++;
        if (log_q.size() !== 8) begin
            n_bad++;
            $display("FAIL nolast_count: got %0d writes, required 8", log_q.size());
        end
        if (log_q.size() == 8) begin
            n_cmp++;
            if (got_wr(log_q[7]) !== exp_wr(8'h22, 32'h407, 0, 1, 1)) begin
                n_bad++;
                $display("FAIL nolast_final: got %h required %h", got_wr(log_q[7]),
                         exp_wr(8'h22, 32'h407, 0, 1, 1));
            end
        end
    endtask

    task automatic test_midburst_reset;
        int c0;
        logic [115:0] got;
        log_q.delete();
        send_req(7, 0, 4'h0, 32'h0);
        send_burst(32'h40, 3, -1, 0, c0);
        bus.beat_valid = 1'b1;
        bus.beat_data  = 32'h99;
        rst = 1'b1;
        @(negedge clk);
        got = {bus.bram_en, bus.bram_we, bus.bram_addr, bus.bram_din, bus.crit_valid,
               bus.crit_data, bus.done, bus.err, bus.req_ready, bus.beat_ready};
        n_cmp++;
        if (got !== {1'b0, 4'h0, 10'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL midreset_outputs: got %h required all zero with req_ready=1 beat_ready=0", got);
        end
        rst = 1'b0;
        settle();
        n_cmp++;
        if (log_q.size() !== 3) begin
            n_bad++;
            $display("FAIL midreset_no_writes: got %0d writes, required 3", log_q.size());
        end
        bus.beat_valid = 1'b0;
        @(negedge clk);
        log_q.delete();
        send_req(0, 1, 4'h0, 32'h0);
        send_burst(32'h700, 8, 7, 0, c0);
        settle();
        n_cmp++;
        if (log_q.size() !== 8) begin
            n_bad++;
            $display("FAIL postreset_count: got %0d writes, required 8", log_q.size());
        end
        if (log_q.size() == 8) begin
            n_cmp++;
            if (got_wr(log_q[0]) !== exp_wr(8'h01, 32'h700, 1, 0, 0)) begin
                n_bad++;
                $display("FAIL postreset_first: got %h required %h", got_wr(log_q[0]),
                         exp_wr(8'h01, 32'h700, 1, 0, 0));
            end
            n_cmp++;
            if (got_wr(log_q[7]) !== exp_wr(8'h00, 32'h707, 0, 1, 0)) begin
                n_bad++;
                $display("FAIL postreset_final: got %h required %h", got_wr(log_q[7]),
                         exp_wr(8'h00, 32'h707, 0, 1, 0));
            end
        end
    endtask

    task automatic test_back_to_back;
        int c0;
        int c1;
        int n = 0;
        log_q.delete();
        bus.req_valid  = 1'b1;
        bus.req_index  = 7'd6;
        bus.req_offset = 3'd4;
        bus.req_wstrb  = 4'h0;
        bus.req_wdata  = 32'h0;
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        // Second request waits with req_valid held high while the first line fills.
        bus.req_index  = 7'd7;
        bus.req_offset = 3'd0;
        send_burst(32'h500, 8, 7, 0, c0);
        n_cmp++;
        if (bus.req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_ready_in_done: got req_ready=%b required 1", bus.req_ready);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        n_cmp++;
        if (bus.beat_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_second_accepted: got beat_ready=%b required 1", bus.beat_ready);
        end
        send_burst(32'h600, 8, 7, 0, c1);
        settle();
        n_cmp++;
        if (log_q.size() !== 16) begin
            n_bad++;
            $display("FAIL b2b_count: got %0d writes, required 16", log_q.size());
        end
        if (log_q.size() == 16) begin
            n_cmp++;
            if (got_wr(log_q[7]) !== exp_wr(8'h33, 32'h507, 0, 1, 0)) begin
                n_bad++;
                $display("FAIL b2b_first_final: got %h required %h", got_wr(log_q[7]),
                         exp_wr(8'h33, 32'h507, 0, 1, 0));
            end
            n_cmp++;
            if (got_wr(log_q[8]) !== exp_wr(8'h38, 32'h600, 1, 0, 0)) begin
                n_bad++;
                $display("FAIL b2b_second_first: got %h required %h", got_wr(log_q[8]),
                         exp_wr(8'h38, 32'h600, 1, 0, 0));
            end
            n_cmp++;
            if (log_q[8].cyc - log_q[7].cyc < 2) begin
                n_bad++;
                $display("FAIL b2b_gap: got %0d cycles, required at least 2", log_q[8].cyc - log_q[7].cyc);
            end
            n_cmp++;
            if (got_wr(log_q[15]) !== exp_wr(8'h3F, 32'h607, 0, 1, 0)) begin
                n_bad++;
                $display("FAIL b2b_second_final: got %h required %h", got_wr(log_q[15]),
                         exp_wr(8'h3F, 32'h607, 0, 1, 0));
            end
        end
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_index  = '0;
        bus.req_offset = '0;
        bus.req_wstrb  = '0;
        bus.req_wdata  = '0;
        bus.beat_valid = 1'b0;
        bus.beat_data  = '0;
        bus.beat_last  = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        test_reset();
        test_aligned();
        test_wrapped();
        test_merge();
        test_length_errors();
        test_midburst_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard stop in case a handshake never completes.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at 200000, required finish");
        $fatal(1);
    end
endmodule
